// File: rtl/traffic_pkg.sv
// Lamp encodings shared by the highway and farm-way light controllers,
// plus sizing helpers for the dwell timer.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } lamp_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit so the longest dwell compare never sits on the saturation value.
  function automatic int timer_w(input int long_cyc, input int red_max);
    return $clog2(max_int(long_cyc, red_max)) + 1;
  endfunction

endpackage

// File: rtl/light_timer.sv
// Dwell timer: clears on request, otherwise counts up and holds at all-ones.
module light_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hw_light_ctrl.sv
// Highway side of the highway/farm-way crossing: holds GREEN until a farm car
// waits, cycles through YELLOW to RED, and hands right-of-way to the farm side.
module hw_light_ctrl
  import traffic_pkg::*;
#(
  parameter int LONG_CYC  = 16,
  parameter int SHORT_CYC = 4,
  parameter int RED_MAX   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_on_fw,
  input  logic       invk_hw,
  output logic       invk_fw,
  output logic [1:0] hw_light,
  output logic       fault
);

  localparam int TW = timer_w(LONG_CYC, RED_MAX);

  localparam logic [TW-1:0] GREEN_LAST  = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(SHORT_CYC - 1);
  localparam logic [TW-1:0] RED_LAST    = TW'(RED_MAX - 1);

  lamp_e          state;
  lamp_e          state_nxt;
  logic [TW-1:0]  timer;
  logic           car_req;
  logic           wd_trip;
  logic           enter_red;
  logic           state_chg;

  // The lamp register is the FSM state itself, so hw_light has no decode logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GREEN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wd_trip   = 1'b0;
    case (state)
      GREEN: begin
        if ((timer >= GREEN_LAST) && (car_req || car_on_fw)) begin
          state_nxt = YELLOW;
        end
      end
      YELLOW: begin
        if (timer == YELLOW_LAST) begin
          state_nxt = RED;
        end
      end
      RED: begin
        // Timer is 0 only on the hand-off cycle, where a hand-back is not yet legal.
        if (invk_hw && (timer != '0)) begin
          state_nxt = GREEN;
        end else if (timer == RED_LAST) begin
          state_nxt = GREEN;
          wd_trip   = 1'b1;
        end
      end
      default: begin
        state_nxt = GREEN;
      end
    endcase
  end

  assign enter_red = (state != RED) && (state_nxt == RED);
  assign state_chg = (state_nxt != state);
  assign hw_light  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      car_req <= 1'b0;
      invk_fw <= 1'b0;
      fault   <= 1'b0;
    end else begin
      invk_fw <= enter_red;
      if (wd_trip) begin
        fault <= 1'b1;
      end
      // A car seen on the edge into RED has already been served by this hand-off.
      if (enter_red) begin
        car_req <= 1'b0;
      end else if (car_on_fw) begin
        car_req <= 1'b1;
      end
    end
  end

  light_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_chg),
    .count (timer)
  );

endmodule

// File: tb/tb_hw_light_ctrl.sv
// Directed and randomized bench for hw_light_ctrl against a lamp-level model.
module tb_hw_light_ctrl;

  localparam int LONG_CYC  = 16;
  localparam int SHORT_CYC = 4;
  localparam int RED_MAX   = 64;
  localparam int TMAX      = (1 << ($clog2(RED_MAX > LONG_CYC ? RED_MAX : LONG_CYC) + 1)) - 1;

  localparam int L_RED = 0, L_GREEN = 1, L_YELLOW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       car_on_fw;
  logic       invk_hw;
  logic       invk_fw;
  logic [1:0] hw_light;
  logic       fault;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference: which lamp is lit, how long it has been lit, pending car, sticky fault.
  int m_lamp, m_dwell;
  bit m_car, m_fault, m_fw, m_ok = 1'b0;

  hw_light_ctrl #(
    .LONG_CYC  (LONG_CYC),
    .SHORT_CYC (SHORT_CYC),
    .RED_MAX   (RED_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .car_on_fw (car_on_fw),
    .invk_hw   (invk_hw),
    .invk_fw   (invk_fw),
    .hw_light  (hw_light),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input bit car, input bit hw, input bit r);
    int nl;
    if (r) begin
      m_lamp = L_GREEN; m_dwell = 0; m_car = 0; m_fault = 0; m_fw = 0; m_ok = 1'b1;
      return;
    end
    nl = m_lamp;
    if (m_lamp == L_GREEN && m_dwell >= LONG_CYC - 1 && (m_car || car)) nl = L_YELLOW;
    else if (m_lamp == L_YELLOW && m_dwell == SHORT_CYC - 1) nl = L_RED;
    else if (m_lamp == L_RED && hw && m_dwell >= 1) nl = L_GREEN;
    else if (m_lamp == L_RED && m_dwell == RED_MAX - 1) begin
      nl = L_GREEN;
      m_fault = 1;
    end
    m_fw = (m_lamp == L_YELLOW && nl == L_RED);
    if (m_fw) m_car = 0;
    else if (car) m_car = 1;
    m_dwell = (nl != m_lamp) ? 0 : ((m_dwell < TMAX) ? m_dwell + 1 : TMAX);
    m_lamp  = nl;
  endtask

  task automatic cycle(input bit car, input bit hw, input bit r);
    car_on_fw = car;
    invk_hw   = hw;
    rst       = r;
    @(negedge clk);
    if (m_ok) begin
      chk("hw_light", hw_light, m_lamp);
      chk("invk_fw",  invk_fw,  m_fw);
      chk("fault",    fault,    m_fault);
      chk("timer",    dut.timer, m_dwell);
      chk("car_req",  dut.car_req, m_car);
    end
    @(posedge clk);
    model_step(car, hw, r);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; car_on_fw = 1'b0; invk_hw = 1'b0;

    // Reset state
    do_reset();
    chk("rst_light", hw_light, 1);
    chk("rst_fw", invk_fw, 0);
    chk("rst_fault", fault, 0);
    chk("rst_timer", dut.timer, 0);

    // Basic handoff followed by farm hand-back on the 5th RED cycle
    for (int c = 0; c <= 25; c++) begin
      if (c == 15) chk("bh_green15", hw_light, 1);
      if (c == 16) chk("bh_yellow16", hw_light, 2);
      if (c == 19) chk("bh_yellow19", hw_light, 2);
      if (c == 19) chk("bh_fw19", invk_fw, 0);
      if (c == 20) chk("bh_red20", hw_light, 0);
      if (c == 20) chk("bh_fw20", invk_fw, 1);
      if (c == 21) chk("bh_fw21", invk_fw, 0);
      if (c == 25) begin
        chk("hb_green", hw_light, 1);
        chk("hb_timer", dut.timer, 0);
        chk("hb_fault", fault, 0);
      end
      cycle(c == 3, c == 24, 1'b0);
    end

    // No car: highway stays green, invk_hw noise ignored
    do_reset();
    for (int c = 0; c < 200; c++) begin
      if (c == 199) chk("nocar_light", hw_light, 1);
      cycle(1'b0, ($urandom % 5) == 0, 1'b0);
    end

    // Watchdog expiry without hand-back, fault stays sticky
    do_reset();
    for (int c = 0; c <= 120; c++) begin
      if (c == 83) chk("wd_red83", hw_light, 0);
      if (c == 84) chk("wd_green84", hw_light, 1);
      if (c == 84) chk("wd_fault84", fault, 1);
      if (c == 120) chk("wd_fault_sticky", fault, 1);
      cycle(c == 0 || c == 100, 1'b0, 1'b0);
    end

    // Hand-back coinciding with watchdog expiry
    do_reset();
    for (int c = 0; c <= 86; c++) begin
      if (c == 84) chk("wdhb_green", hw_light, 1);
      if (c == 86) chk("wdhb_fault", fault, 0);
      cycle(c == 0, c == 83, 1'b0);
    end

    // Ignored inputs: invk_hw in GREEN/YELLOW, car held through RED
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      if (c == 3)  chk("ign_green3", hw_light, 1);
      if (c == 18) chk("ign_yellow18", hw_light, 2);
      if (c == 28) chk("ign_red28", hw_light, 0);
      if (c == 46) chk("ign_green46", hw_light, 1);
      if (c == 47) chk("ign_yellow47", hw_light, 2);
      cycle(c == 5 || (c >= 20 && c <= 30), c == 2 || c == 17 || c == 30, 1'b0);
    end

    // Reset in the second YELLOW cycle, with a car present
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      if (c == 17) chk("ry_yellow17", hw_light, 2);
      if (c == 18) begin
        chk("ry_light", hw_light, 1);
        chk("ry_fw", invk_fw, 0);
        chk("ry_car", dut.car_req, 0);
      end
      if (c == 22) chk("ry_no_red", hw_light, 1);
      cycle(c == 0 || c == 17, 1'b0, c == 17);
    end

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom % 10) == 0, ($urandom % 6) == 0, ($urandom % 400) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
